datachk: RTL and testbench

DATACHK -- requirements
Module: datachk

---
 rtl/datachk_pkg.sv | 32 +++
 rtl/datachk_cmp.sv | 32 +++
 rtl/datachk.sv | 195 +++++++++++++++++++
 tb/tb_datachk.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/datachk_pkg.sv
// datachk_pkg -- shared definitions for the BRAM data checker.
//
// Contents:
//   *_DEF       default values for the NBANK / DW / AW / RD_LAT parameters
//   state_t     checker FSM states (IDLE, READ, DRAIN, DONE)
//   exp_word()  expected word for bank b at index i: seed + NBANK*i + b (mod 2^32)
//
// Optional feature macro used elsewhere: DATACHK_STOP_ON_ERR_EN.

package datachk_pkg;

    localparam int NBANK_DEF  = 4;
    localparam int DW_DEF     = 32;
    localparam int AW_DEF     = 16;
    localparam int RD_LAT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The pattern wraps naturally through zero because the sum is 32 bits wide.
    function automatic logic [31:0] exp_word(input logic [31:0] seed,
                                             input logic [31:0] idx,
                                             input int          nbank,
                                             input int          bank);
        return seed + (idx * 32'(nbank)) + 32'(bank);
    endfunction

endpackage

// File: rtl/datachk_cmp.sv
// datachk_cmp -- expected-value generator and compare for one BRAM bank.
//
// Ports:
//   i_seed  in  32   latched run seed
//   i_idx   in  IW   word index of the data currently on i_dout
//   i_dout  in  DW   word returned by this bank
//   o_mis   out 1    word differs from the expected pattern (not gated by valid)

module datachk_cmp
    import datachk_pkg::*;
#(
    parameter int BANK  = 0,
    parameter int NBANK = NBANK_DEF,
    parameter int DW    = DW_DEF,
    parameter int IW    = AW_DEF - 2
) (
    input  logic [31:0]   i_seed,
    input  logic [IW-1:0] i_idx,
    input  logic [DW-1:0] i_dout,
    output logic          o_mis
);

    logic [31:0]   w_exp32;
    logic [DW-1:0] w_exp;

    always_comb begin
        w_exp32 = exp_word(i_seed, 32'(i_idx), NBANK, BANK);
        w_exp   = DW'(w_exp32);
        o_mis   = (i_dout != w_exp);
    end

endmodule

// File: rtl/datachk.sv
// datachk -- reads NBANK BRAM banks in lockstep and checks every word against
// the generator pattern seed + NBANK*i + b, counting mismatches.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start               one-cycle pulse, begins a run from IDLE or DONE
//   clear               level, aborts and zeroes results (wins over start)
//   length, seed        words per bank (clamped to 2^(AW-2)), pattern seed
//   busy, done          busy in READ/DRAIN; done held in DONE
//   err_count           saturating count of mismatching words
//   err_seen, first_err_addr, first_err_bank   first mismatch of the run
//   bram_*              BRAM port per bank (read only; we/din tied to 0)
//   o_dbg_state         current FSM state (state_t encoding)
//
// Handshake: start is accepted only in IDLE/DONE when clear is low; results
// are final in the cycle done first reads 1.
//
// Macro DATACHK_STOP_ON_ERR_EN: when defined, address issue stops the cycle
// after the first mismatch and the FSM drains the in-flight reads.

module datachk
    import datachk_pkg::*;
#(
    parameter int NBANK  = NBANK_DEF,
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         clear,
    input  logic [15:0]                  length,
    input  logic [31:0]                  seed,
    output logic                         busy,
    output logic                         done,
    output logic [31:0]                  err_count,
    output logic [AW-1:0]                first_err_addr,
    output logic [$clog2(NBANK)-1:0]     first_err_bank,
    output logic                         err_seen,
    output logic [NBANK-1:0]             bram_clk,
    output logic [NBANK-1:0]             bram_rst,
    output logic [NBANK-1:0]             bram_en,
    output logic [NBANK-1:0][3:0]        bram_we,
    output logic [NBANK-1:0][AW-1:0]     bram_addr,
    output logic [NBANK-1:0][DW-1:0]     bram_din,
    input  logic [NBANK-1:0][DW-1:0]     bram_dout,
    output logic [1:0]                   o_dbg_state
);

    localparam int IW  = AW - 2;
    localparam int BW  = $clog2(NBANK);
    localparam int CW  = $clog2(NBANK + 1);
    localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [16:0] MAX_LEN = 17'(1) << IW;

    state_t            r_state, w_next;
    logic [IW-1:0]     r_idx, r_len_m1;
    logic [31:0]       r_seed;
    logic [DCW-1:0]    r_drain;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [IW-1:0]     r_pipe_idx [RD_LAT];
    logic [31:0]       r_err_count;
    logic              r_err_seen;
    logic [AW-1:0]     r_first_addr;
    logic [BW-1:0]     r_first_bank;

    logic [NBANK-1:0]  w_mis, w_mis_v;
    logic              w_cmp_vld, w_any_mis, w_start_ok;
    logic [CW-1:0]     w_nmis;
    logic [BW-1:0]     w_low_bank;
    logic [32:0]       w_sum;
    logic [16:0]       w_len_eff;
    logic [IW-1:0]     w_len_m1;

    // ---------------------------------------------------------------- compare
    for (genvar b = 0; b < NBANK; b++) begin : g_cmp
        datachk_cmp #(.BANK(b), .NBANK(NBANK), .DW(DW), .IW(IW)) u_cmp (
            .i_seed (r_seed),
            .i_idx  (r_pipe_idx[RD_LAT-1]),
            .i_dout (bram_dout[b]),
            .o_mis  (w_mis[b])
        );
    end

    always_comb begin
        w_cmp_vld  = r_pipe_vld[RD_LAT-1];
        w_mis_v    = w_mis & {NBANK{w_cmp_vld}};
        w_any_mis  = |w_mis_v;
        w_nmis     = '0;
        w_low_bank = '0;
        // Walk downward so the lowest mismatching bank is the last one written.
        for (int b = NBANK - 1; b >= 0; b--) begin
            if (w_mis_v[b]) begin
                w_nmis     = w_nmis + CW'(1);
                w_low_bank = BW'(b);
            end
        end
        w_sum      = {1'b0, r_err_count} + 33'(w_nmis);
        w_len_eff  = (17'(length) > MAX_LEN) ? MAX_LEN : 17'(length);
        w_len_m1   = IW'(w_len_eff - 17'd1);
        w_start_ok = start && !clear && (r_state == ST_IDLE || r_state == ST_DONE);
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_next = (length == 16'd0) ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                if (r_idx == r_len_m1) w_next = ST_DRAIN;
`ifdef DATACHK_STOP_ON_ERR_EN
                if (w_any_mis) w_next = ST_DRAIN;
`endif
            end
            ST_DRAIN: begin
                if (r_drain == DCW'(RD_LAT - 1)) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (clear) w_next = ST_IDLE;
    end

    always_comb begin
        busy        = (r_state == ST_READ) || (r_state == ST_DRAIN);
        done        = (r_state == ST_DONE);
        bram_en     = {NBANK{r_state == ST_READ}};
        o_dbg_state = r_state;
        for (int b = 0; b < NBANK; b++) bram_addr[b] = {r_idx, 2'b00};
    end

    assign bram_clk       = {NBANK{clk}};
    assign bram_rst       = {NBANK{reset}};
    assign bram_we        = '0;
    assign bram_din       = '0;
    assign err_count      = r_err_count;
    assign err_seen       = r_err_seen;
    assign first_err_addr = r_first_addr;
    assign first_err_bank = r_first_bank;

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx        <= '0;
            r_len_m1     <= '0;
            r_seed       <= '0;
            r_drain      <= '0;
            r_pipe_vld   <= '0;
            for (int k = 0; k < RD_LAT; k++) r_pipe_idx[k] <= '0;
            r_err_count  <= '0;
            r_err_seen   <= 1'b0;
            r_first_addr <= '0;
            r_first_bank <= '0;
        end else begin
            // Index returns to 0 whenever READ ends so bram_addr idles at 0.
            r_idx   <= (r_state == ST_READ && w_next == ST_READ) ? r_idx + IW'(1) : '0;
            r_drain <= (r_state == ST_DRAIN) ? r_drain + DCW'(1) : '0;

            // Index/valid pipeline matching the BRAM read latency.
            r_pipe_vld[0] <= (r_state == ST_READ) && !clear;
            r_pipe_idx[0] <= r_idx;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1] && !clear;
                r_pipe_idx[k] <= r_pipe_idx[k-1];
            end

            if (w_start_ok) begin
                r_seed   <= seed;
                r_len_m1 <= w_len_m1;
            end

            if (clear || w_start_ok) begin
                r_err_count  <= '0;
                r_err_seen   <= 1'b0;
                r_first_addr <= '0;
                r_first_bank <= '0;
            end else if (w_cmp_vld) begin
                r_err_count <= w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
                if (w_any_mis && !r_err_seen) begin
                    r_err_seen   <= 1'b1;
                    r_first_addr <= {r_pipe_idx[RD_LAT-1], 2'b00};
                    r_first_bank <= w_low_bank;
                end
            end
        end
    end

endmodule

// File: tb/tb_datachk.sv
// tb_datachk -- directed bench for datachk with a BRAM model, read monitor
// and an expected-result queue filled when each run is started.
// Define DATACHK_STOP_ON_ERR_EN for both DUT and bench to exercise stop-on-error.

module tb_datachk;

    localparam int NBANK  = 4;
    localparam int DW     = 32;
    localparam int AW     = 16;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 16384;
    localparam int LIMIT  = 20000;

    logic                     clk, reset, start, clear;
    logic [15:0]              length;
    logic [31:0]              seed;
    logic                     busy, done, err_seen;
    logic [31:0]              err_count;
    logic [AW-1:0]            first_err_addr;
    logic [1:0]               first_err_bank;
    logic [NBANK-1:0]         bram_clk, bram_rst, bram_en;
    logic [NBANK-1:0][3:0]    bram_we;
    logic [NBANK-1:0][AW-1:0] bram_addr;
    logic [NBANK-1:0][DW-1:0] bram_din, bram_dout;
    logic [1:0]               dbg_state;

    int n_checks = 0;
    int n_err    = 0;
    int rd_total = 0;
    int addr_bad = 0;
    int mon_idx  = 0;

    // {reads[15:0], seen, bank[1:0], addr[15:0], count[31:0]}
    logic [66:0] exp_q[$];
    logic [31:0] mem [NBANK][DEPTH];
    logic [DW-1:0] rd_pipe [NBANK][RD_LAT];

    datachk #(.NBANK(NBANK), .DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .length(length), .seed(seed),
        .busy(busy), .done(done), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_bank(first_err_bank),
        .err_seen(err_seen),
        .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_en(bram_en),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout), .o_dbg_state(dbg_state)
    );

    // ------------------------------------------------------------ clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ BRAM model
    always @(posedge clk) begin
        for (int b = 0; b < NBANK; b++) begin
            if (bram_en[b]) rd_pipe[b][0] <= mem[b][bram_addr[b][AW-1:2]];
            for (int k = 1; k < RD_LAT; k++) rd_pipe[b][k] <= rd_pipe[b][k-1];
        end
    end

    always_comb begin
        for (int b = 0; b < NBANK; b++) bram_dout[b] = rd_pipe[b][RD_LAT-1];
    end

    // ------------------------------------------------------------ read monitor
    always @(negedge clk) begin
        if (bram_en[0]) begin
            rd_total++;
            for (int b = 0; b < NBANK; b++) begin
                if (bram_en[b] !== 1'b1 || bram_addr[b] !== AW'(mon_idx * 4) ||
                    bram_we[b] !== 4'd0 || bram_din[b] !== '0)
                    addr_bad++;
            end
            mon_idx++;
        end else begin
            if (bram_en !== '0) addr_bad++;
            mon_idx = 0;
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] sd);
        for (int i = 0; i < DEPTH; i++)
            for (int b = 0; b < NBANK; b++)
                mem[b][i] = sd + 32'(NBANK * i + b);
    endtask

    task automatic corrupt(input int b, input int i);
        mem[b][i] = mem[b][i] + 32'h0001_0001;
    endtask

    task automatic model_push(input logic [15:0] len, input logic [31:0] sd, output int lat);
        int          nr;
        logic [31:0] cnt;
        logic        seen;
        logic [1:0]  fb;
        logic [15:0] fa;
        nr = (int'(len) > DEPTH) ? DEPTH : int'(len);
        cnt = 0; seen = 0; fb = 0; fa = 0;
        for (int i = 0; i < nr; i++) begin
            for (int b = 0; b < NBANK; b++) begin
                if (mem[b][i] !== sd + 32'(NBANK * i + b)) begin
                    if (cnt != 32'hFFFF_FFFF) cnt++;
                    if (!seen) begin
                        seen = 1'b1;
                        fa   = 16'(i * 4);
                        fb   = 2'(b);
                    end
`ifdef DATACHK_STOP_ON_ERR_EN
                    if (nr > i + RD_LAT + 1) nr = i + RD_LAT + 1;
`endif
                end
            end
        end
        lat = (nr == 0) ? 1 : nr + RD_LAT + 1;
        exp_q.push_back({16'(nr), seen, fb, fa, cnt});
    endtask

    task automatic run(input logic [15:0] len, input logic [31:0] sd,
                       input int mid_start, input string tag);
        int          lat, k, rd0, bad0;
        logic [15:0] e_reads, e_addr;
        logic        e_seen;
        logic [1:0]  e_bank;
        logic [31:0] e_cnt;
        model_push(len, sd, lat);
        rd0  = rd_total;
        bad0 = addr_bad;
        @(negedge clk);
        length = len; seed = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (done !== 1'b1 && k < LIMIT) begin
            if (k == mid_start) begin
                start = 1'b1; length = 16'd0; seed = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        {e_reads, e_seen, e_bank, e_addr, e_cnt} = exp_q.pop_front();
        check({tag, " latency"},   64'(k), 64'(lat));
        check({tag, " reads"},     64'(rd_total - rd0), 64'(e_reads));
        check({tag, " addr_seq"},  64'(addr_bad - bad0), 64'd0);
        check({tag, " err_count"}, 64'(err_count), 64'(e_cnt));
        check({tag, " err_seen"},  64'(err_seen), 64'(e_seen));
        check({tag, " first_addr"},64'(first_err_addr), 64'(e_addr));
        check({tag, " first_bank"},64'(first_err_bank), 64'(e_bank));
        check({tag, " busy"},      64'(busy), 64'd0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int          rd0;
        logic [31:0] sd;
        logic [15:0] len;

        reset = 1'b1; start = 1'b0; clear = 1'b0; length = '0; seed = '0;
        fill(32'd0);
        repeat (3) @(negedge clk);
        check("rst busy",       64'(busy), 64'd0);
        check("rst done",       64'(done), 64'd0);
        check("rst bram_en",    64'(bram_en), 64'd0);
        check("rst bram_addr",  64'(bram_addr), 64'd0);
        check("rst err_count",  64'(err_count), 64'd0);
        check("rst err_seen",   64'(err_seen), 64'd0);
        check("rst first_addr", 64'(first_err_addr), 64'd0);
        check("rst first_bank", 64'(first_err_bank), 64'd0);
        check("rst state",      64'(dbg_state), 64'd0);
        reset = 1'b0;

        // Clean run, then done must hold.
        fill(32'h100);
        run(16'd8, 32'h100, 0, "clean");
        repeat (3) @(negedge clk);
        check("done_hold", 64'(done), 64'd1);

        fill(32'd0); corrupt(2, 5);
        run(16'd8, 32'd0, 0, "single");

        fill(32'd0); corrupt(1, 0); corrupt(3, 0);
        run(16'd8, 32'd0, 0, "simul");

        run(16'd0, 32'd0, 0, "len0");

        // Full clamp, wrapping seed, error on the very last word.
        fill(32'hFFFF_FFFE); corrupt(3, DEPTH - 1);
        run(16'hFFFF, 32'hFFFF_FFFE, 0, "len_max");

        // Start pulsed in READ is ignored; a later error keeps first_* fields.
        fill(32'h55); corrupt(3, 7); corrupt(0, 9);
        run(16'd12, 32'h55, 3, "mid_start");

        for (int r = 0; r < 3; r++) begin
            sd  = $urandom;
            len = 16'($urandom_range(5, 40));
            fill(sd);
            for (int c = 0; c < 3; c++)
                corrupt(int'($urandom_range(0, NBANK - 1)), int'($urandom_range(0, int'(len) - 1)));
            run(len, sd, 0, "random");
        end

        // Clear in READ cycle 3 with a simultaneous start.
        fill(32'd0); corrupt(0, 0);
        rd0 = rd_total;
        @(negedge clk); length = 16'd20; seed = 32'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("clr pre busy", 64'(busy), 64'd1);
        clear = 1'b1; start = 1'b1; length = 16'd5;
        @(negedge clk);
        check("clr busy",       64'(busy), 64'd0);
        check("clr done",       64'(done), 64'd0);
        check("clr bram_en",    64'(bram_en), 64'd0);
        check("clr err_count",  64'(err_count), 64'd0);
        check("clr err_seen",   64'(err_seen), 64'd0);
        check("clr first_addr", 64'(first_err_addr), 64'd0);
        check("clr first_bank", 64'(first_err_bank), 64'd0);
        check("clr state",      64'(dbg_state), 64'd0);
        clear = 1'b0; start = 1'b0;
        repeat (RD_LAT + 3) @(negedge clk);
        check("clr after busy",  64'(busy), 64'd0);
        check("clr after count", 64'(err_count), 64'd0);
        check("clr reads",       64'(rd_total - rd0), 64'd3);

        // Reset in the middle of READ leaves no residual compares.
        @(negedge clk); length = 16'd20; seed = 32'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid busy",    64'(busy), 64'd0);
        check("rstmid bram_en", 64'(bram_en), 64'd0);
        repeat (RD_LAT + 3) @(negedge clk);
        check("rstmid err_count", 64'(err_count), 64'd0);
        check("rstmid err_seen",  64'(err_seen), 64'd0);
        check("rstmid done",      64'(done), 64'd0);

`ifdef DATACHK_STOP_ON_ERR_EN
        fill(32'd0); corrupt(1, 2);
        run(16'd100, 32'd0, 0, "stop_on_err");
`endif

        check("queue empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
